adder_stream_ctrl: RTL and testbench
====================================

// Module: adder_stream_ctrl
// PURPOSE
//  Valid/ready streaming front/back end for the registered 64-bit prefix adder wrapper.
//  - Accepts operand pairs, drives the wrapper's a/b inputs and tracks in-flight ops.
//  - Captures sum/cout into a small result FIFO and presents them on a valid/ready output.
//  - Credit-based issue: an op issues only if a result slot is guaranteed, so results are never dropped.
// PARAMETERS
//  W         64  operand/sum width; must match the attached adder wrapper
//  LAT       2   adder wrapper latency in cycles (input reg + output reg)
//  DEPTH     4   result FIFO entries (power of 2, >= LAT)
//  TAG_W     4   tag width (used only when ADDER_STREAM_TAG_EN is defined)
// PORTS
//  clk        in   1        clock (also drives the adder wrapper)
//  rst_n      in   1        async active-low reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        controller can accept an operand pair this cycle
//  in_a       in   W        operand A
//  in_b       in   W        operand B
//  in_tag     in   TAG_W    op tag (ADDER_STREAM_TAG_EN only)
//  add_a      out  W        to wrapper a
//  add_b      out  W        to wrapper b
//  add_sum    in   W        from wrapper sum
//  add_cout   in   1        from wrapper cout
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_sum    out  W        result sum
//  out_cout   out  1        result carry-out
//  out_tag    out  TAG_W    tag of result (ADDER_STREAM_TAG_EN only)
//  inflight   out  clog2(DEPTH+1)  ops issued but not yet popped (issued + FIFO occupancy)
// BEHAVIOUR
//  - Reset (async assert, sync deassert): in_ready=0 for the reset cycle, then 1.
//    out_valid=0, inflight=0, add_a/add_b=0, FIFO empty, valid shift register cleared.
//  - Wrapper registers are not reset: their contents after reset are ignored.
//    Only results tagged valid by the LAT-deep valid shift register are captured.
//  - Issue:
//    - in_ready = (inflight < DEPTH) || (out_valid && out_ready).
//    - The fire cycle (in_valid && in_ready) drives add_a/add_b combinationally from in_a/in_b.
//    - The same cycle shifts a 1 into valid_sr[0]; a non-fire cycle shifts in 0 and add_a/add_b hold.
//  - Capture: when valid_sr[LAT-1]=1, add_sum/add_cout are written to the FIFO.
//    Capture occurs exactly LAT cycles after fire. Capture never finds the FIFO full; this is guaranteed by credits.
//  - Output: out_valid = FIFO non-empty. Data is the FIFO head.
//    Pop on out_valid && out_ready. Data holds stable while out_valid && !out_ready.
//  - inflight: +1 on fire, -1 on pop, unchanged on simultaneous fire+pop.
//  - Back-to-back: throughput is 1 op/cycle with out_ready held 1. First result appears LAT+1 cycles after the first fire (FIFO registered).
//  - Arithmetic: unsigned, {cout,sum} = a+b mod 2^(W+1). No saturation. The wrapper computes it; the controller never alters data.
//  - Ordering: strictly in-order. The FIFO pointers wrap modulo DEPTH. Full/empty use an extra pointer bit.
//  - Reset mid-operation: all in-flight ops and FIFO contents are discarded. No out_valid occurs until a new fire.
// CONFIGURATION
//  ADDER_STREAM_TAG_EN defined:
//    - in_tag is delayed LAT cycles in a tag shift register alongside valid_sr.
//    - The tag is stored with the result. out_tag = head tag.
//  ADDER_STREAM_TAG_EN undefined:
//    - in_tag/out_tag ports and tag storage are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Package adder_stream_pkg:
//    - W, TAG_W defaults
//    - typedef result_t {logic cout; logic [W-1:0] sum; [tag]}
//    - function clog2 helper for counter widths
//  - Sub-module adder_stream_fifo:
//    - synchronous single-clock FIFO of result_t, DEPTH entries
//    - push/pop/full/empty/count; registered head; async active-low reset.
//  - Top contains the valid/tag shift registers, the credit/inflight counter and the wrapper-facing port muxing.
// TESTING
//  1. Reset: hold rst_n=0 with random in_*.
//     -> out_valid=0, inflight=0, in_ready=0. After release, in_ready=1 and no spurious out_valid.
//  2. Single op: a=64'hFFFF_FFFF_FFFF_FFFF, b=1.
//     -> out_valid at fire+LAT+1, out_sum=0, out_cout=1, inflight back to 0 after pop.
//  3. Streaming: 100 back-to-back random ops with out_ready=1.
//     -> 100 in-order results matching {cout,sum}=a+b, in_ready never drops.
//  4. Backpressure: out_ready=0, continuous in_valid.
//     -> exactly DEPTH ops accepted, in_ready=0 after the DEPTH-th fire.
//     -> out_ready=1 then drains in order with zero loss.
//  5. Simultaneous fire+pop at inflight=DEPTH:
//     -> the op is accepted, inflight stays DEPTH, no overflow, ordering preserved.
//  6. Mid-stream reset with 3 ops in flight:
//     -> all discarded, the next op a=5, b=7 returns out_sum=12, cout=0 as first result.
//     -> with ADDER_STREAM_TAG_EN, out_tag equals in_tag for every result.

Source files
------------

// File: rtl/adder_stream_pkg.sv
// Shared widths, the result record and a width helper for the streaming adder controller.
// Defining ADDER_STREAM_TAG_EN adds a tag field to every result.
package adder_stream_pkg;

  localparam int W     = 64;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] sum;
`ifdef ADDER_STREAM_TAG_EN
    logic [TAG_W-1:0] tag;
`endif
  } result_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_stream_if.sv
// Operand-in / result-out valid/ready streams of the adder controller.
// The tag signals exist only when ADDER_STREAM_TAG_EN is defined.
interface adder_stream_if;
  import adder_stream_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADDER_STREAM_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
`endif

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef ADDER_STREAM_TAG_EN
    , output in_tag, input out_tag
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef ADDER_STREAM_TAG_EN
    , input in_tag, output out_tag
`endif
  );

endinterface

// File: rtl/adder_stream_fifo.sv
// Single-clock result FIFO of result_t; pointers carry one extra bit so full and empty
// are distinguishable, and the head is read straight from the storage flops.
module adder_stream_fifo
  import adder_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  result_t                 push_data,
  input  logic                    pop,
  output result_t                 head,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en;
  logic        rd_en;
  result_t     mem_q [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/adder_stream_ctrl.sv
// Valid/ready front/back end for a registered LAT-cycle adder wrapper with credit-based issue.
// Optional ADDER_STREAM_TAG_EN carries a per-op tag alongside the valid shift register.
module adder_stream_ctrl
  import adder_stream_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adder_stream_if.slave               s,
  output logic [W-1:0]                add_a,
  output logic [W-1:0]                add_b,
  input  logic [W-1:0]                add_sum,
  input  logic                        add_cout,
  output logic [clog2(DEPTH+1)-1:0]   inflight
);

  localparam int            CW      = clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic           ready_en_q, ready_en_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [LAT-1:0] valid_sr_q, valid_sr_d;
  logic [W-1:0]   add_a_q, add_a_d;
  logic [W-1:0]   add_b_q, add_b_d;
  logic           fire;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [clog2(DEPTH):0] fifo_count;
  result_t        cap_data;
  result_t        head;
`ifdef ADDER_STREAM_TAG_EN
  logic [TAG_W-1:0] tag_sr_q [LAT];
  logic [TAG_W-1:0] tag_sr_d [LAT];
`endif

  // A pop this cycle frees a credit, so a full controller may still accept.
  assign pop        = s.out_valid && s.out_ready;
  assign s.in_ready = ready_en_q && ((inflight_q < DEPTH_C) || pop);
  assign fire       = s.in_valid && s.in_ready;

  always_comb begin
    ready_en_d = 1'b1;
    add_a_d    = fire ? s.in_a : add_a_q;
    add_b_d    = fire ? s.in_b : add_b_q;
    valid_sr_d = '0;
    valid_sr_d[0] = fire;
    for (int i = 1; i < LAT; i++) valid_sr_d[i] = valid_sr_q[i-1];
`ifdef ADDER_STREAM_TAG_EN
    tag_sr_d[0] = s.in_tag;
    for (int i = 1; i < LAT; i++) tag_sr_d[i] = tag_sr_q[i-1];
`endif
    inflight_d = inflight_q;
    unique case ({fire, pop})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values; always_comb uses =.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      inflight_q <= '0;
      valid_sr_q <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
`ifdef ADDER_STREAM_TAG_EN
      for (int i = 0; i < LAT; i++) tag_sr_q[i] <= '0;
`endif
    end else begin
      ready_en_q <= ready_en_d;
      inflight_q <= inflight_d;
      valid_sr_q <= valid_sr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
`ifdef ADDER_STREAM_TAG_EN
      for (int i = 0; i < LAT; i++) tag_sr_q[i] <= tag_sr_d[i];
`endif
    end
  end

  // Wrapper output lines up with valid_sr[LAT-1]; anything else on add_sum is stale.
  always_comb begin
    cap_data      = '0;
    cap_data.sum  = add_sum;
    cap_data.cout = add_cout;
`ifdef ADDER_STREAM_TAG_EN
    cap_data.tag  = tag_sr_q[LAT-1];
`endif
  end

  adder_stream_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (valid_sr_q[LAT-1]),
    .push_data (cap_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign add_a       = add_a_d;
  assign add_b       = add_b_d;
  assign inflight    = inflight_q;
  assign s.out_valid = !fifo_empty;
  assign s.out_sum   = head.sum;
  assign s.out_cout  = head.cout;
`ifdef ADDER_STREAM_TAG_EN
  assign s.out_tag   = head.tag;
`endif

  capture_never_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_sr_q[LAT-1] && fifo_full));
  fifo_within_credits_a: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= inflight_q);

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Self-checking bench for adder_stream_ctrl: a behavioural wrapper model, random stimulus,
// and a scoreboard queue drained by an independent output monitor.
`timescale 1ns/1ps
module tb_adder_stream_ctrl;
  import adder_stream_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = clog2(DEPTH+1);

  typedef struct {
    logic [W-1:0]     sum;
    logic             cout;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_cout;
  logic [CW-1:0] inflight;
  logic [W-1:0]  wr_a, wr_b;

  adder_stream_if bus ();

  adder_stream_ctrl #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .inflight (inflight)
  );

  always #5 clk = ~clk;

  // Registered adder wrapper: input register then output register, never reset.
  always @(posedge clk) begin
    wr_a <= add_a;
    wr_b <= add_b;
    {add_cout, add_sum} <= {1'b0, wr_a} + {1'b0, wr_b};
  end

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   results  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every accepted result is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          results++;
          check("result_sum", bus.out_sum, e.sum);
          check("result_cout", bus.out_cout, e.cout);
`ifdef ADDER_STREAM_TAG_EN
          check("result_tag", bus.out_tag, e.tag);
`endif
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = '1;
    return v;
  endfunction

  // One cycle of stimulus, entered and left at posedge+1; the expectation is queued on fire.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TAG_W-1:0] t, output logic fired);
    exp_t e;
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
`ifdef ADDER_STREAM_TAG_EN
    bus.in_tag   = t;
`endif
    @(negedge clk);
    fired = bus.in_valid && bus.in_ready;
    if (fired) begin
      {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
      e.tag = t;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(output logic fired);
    drive(1'b1, rand_word(), rand_word(), TAG_W'($urandom), fired);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.out_valid === 1'b0) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             fired;
    int               fires;
    int               drops;
    int               lat;
    int               base;
    logic [TAG_W-1:0] t6;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
`ifdef ADDER_STREAM_TAG_EN
    bus.in_tag    = '0;
`endif

    // Reset with random traffic on the inputs.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = rand_word();
      bus.in_b     = rand_word();
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_inflight", inflight, 0);
      check("rst_in_ready", bus.in_ready, 1'b0);
    end
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_cycle_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_no_out_valid", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Single op: all-ones + 1 wraps to zero with carry out.
    drive(1'b1, '1, 64'd1, TAG_W'(4'hA), fired);
    idle();
    check("single_fired", fired, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("single_latency", lat, LAT + 1);
    check("single_sum", bus.out_sum, 0);
    check("single_cout", bus.out_cout, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_inflight_after_pop", inflight, 0);
    @(posedge clk);
    #1;

    // Back-to-back streaming with the consumer always ready.
    base  = results;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      drive_rand(fired);
      if (!fired) drops++;
    end
    idle();
    check("stream_in_ready_drops", drops, 0);
    drain("stream_drain", 50);
    check("stream_result_count", results - base, 100);

    // Backpressure: consumer stalled, producer keeps offering.
    bus.out_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      drive_rand(fired);
      if (fired) fires++;
    end
    idle();
    check("bp_accepted", fires, DEPTH);
    @(negedge clk);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    check("bp_inflight", inflight, DEPTH);
    check("bp_out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain("bp_drain", 40);

    // Fire and pop in the same cycle while every credit is taken.
    bus.out_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand(fired);
      if (fired) fires++;
    end
    idle();
    check("fp_fill", fires, DEPTH);
    repeat (LAT + 2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drive_rand(fired);
    idle();
    bus.out_ready = 1'b0;
    check("fp_fired", fired, 1'b1);
    @(negedge clk);
    check("fp_inflight", inflight, DEPTH);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain("fp_drain", 40);

    // Reset with three ops in flight, then a fresh op must be the first result.
    for (int i = 0; i < 3; i++) drive_rand(fired);
    rst_n = 1'b0;
    idle();
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_inflight", inflight, 0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    t6 = TAG_W'($urandom);
    drive(1'b1, 64'd5, 64'd7, t6, fired);
    idle();
    check("midrst_fired", fired, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("midrst_latency", lat, LAT + 1);
    check("midrst_first_sum", bus.out_sum, 12);
    check("midrst_first_cout", bus.out_cout, 1'b0);
`ifdef ADDER_STREAM_TAG_EN
    check("midrst_first_tag", bus.out_tag, t6);
`endif
    @(posedge clk);
    #1;
    drain("final_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
